// File: rtl/vga_fb_fill_engine_if.sv
// rtl/vga_fb_fill_engine_if.sv - fill-command and RAM write-port bundle for vga_fb_fill_engine
interface vga_fb_fill_engine_if #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_DEPTH   = 8
);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int PW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int CW = 3 * COLOR_DEPTH;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [XW:0]   cmd_w;
  logic [YW:0]   cmd_h;
  logic [CW-1:0] cmd_color;
  logic          wr_en;
  logic [PW:0]   wr_addr;
  logic [CW-1:0] wr_data;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vga_fb_fill_engine.sv
// rtl/vga_fb_fill_engine.sv - double-buffered rectangle-fill writer into the back frame-buffer bank
// FB_CLIP_EN: clip out-of-bounds rectangles to the screen instead of rejecting them with cmd_err.
module vga_fb_fill_engine #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_DEPTH   = 8
) (
  input  logic                  sys_clk_i,
  input  logic                  reset_i,
  vga_fb_fill_engine_if.slave   fb,
  input  logic                  swap_req_i,
  input  logic                  frame_start_i,
  output logic                  front_bank_o,
  output logic                  swap_pending_o,
  output logic                  busy_o,
  output logic                  cmd_err_o
);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int PW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int CW = 3 * COLOR_DEPTH;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [XW:0]   col_left_q, col_left_d, width_q, width_d;
  logic [YW:0]   row_left_q, row_left_d;
  logic [CW-1:0] color_q, color_d;
  logic          bank_q, bank_d, wr_en_q, wr_en_d, err_q, err_d;
  logic          front_q, front_d, pend_q, pend_d;

  logic          accept, reject, empty, last_px;
  logic          x_ge, y_ge, x_over, y_over;
  logic [XW+1:0] x_end;
  logic [YW+1:0] y_end;
  logic [XW:0]   eff_w;
  logic [YW:0]   eff_h;
  logic [PW-1:0] start_addr;

  assign accept  = fb.cmd_valid && fb.cmd_ready;
  assign last_px = (col_left_q == '0) && (row_left_q == '0);

  // Bounds are evaluated one bit wider than the operands so the sums cannot wrap.
  always_comb begin
    x_end  = (XW+2)'(fb.cmd_x) + (XW+2)'(fb.cmd_w);
    y_end  = (YW+2)'(fb.cmd_y) + (YW+2)'(fb.cmd_h);
    x_ge   = (XW+2)'(fb.cmd_x) >= (XW+2)'(SCREEN_WIDTH);
    y_ge   = (YW+2)'(fb.cmd_y) >= (YW+2)'(SCREEN_HEIGHT);
    x_over = x_end > (XW+2)'(SCREEN_WIDTH);
    y_over = y_end > (YW+2)'(SCREEN_HEIGHT);
`ifdef FB_CLIP_EN
    eff_w  = x_over ? (XW+1)'((XW+2)'(SCREEN_WIDTH) - (XW+2)'(fb.cmd_x)) : fb.cmd_w;
    eff_h  = y_over ? (YW+1)'((YW+2)'(SCREEN_HEIGHT) - (YW+2)'(fb.cmd_y)) : fb.cmd_h;
    reject = 1'b0;
    empty  = x_ge || y_ge || (eff_w == '0) || (eff_h == '0);
`else
    eff_w  = fb.cmd_w;
    eff_h  = fb.cmd_h;
    reject = x_ge || y_ge || x_over || y_over;
    empty  = (eff_w == '0) || (eff_h == '0);
`endif
    start_addr = PW'(fb.cmd_y) * PW'(SCREEN_WIDTH) + PW'(fb.cmd_x);
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !reject)      state_d = FILL;
      FILL: if (!wr_en_q || last_px)    state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == FILL);
    fb.cmd_ready = (state_q == IDLE) && !pend_q && !reset_i;
  end

  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    col_left_d = col_left_q;
    row_left_d = row_left_q;
    width_d    = width_q;
    color_d    = color_q;
    bank_d     = bank_q;
    wr_en_d    = wr_en_q;
    err_d      = 1'b0;
    if (accept) begin
      if (reject) begin
        err_d = 1'b1;
      end else begin
        wr_en_d    = !empty;
        addr_d     = start_addr;
        row_base_d = start_addr;
        width_d    = eff_w;
        col_left_d = eff_w - (XW+1)'(1);
        row_left_d = eff_h - (YW+1)'(1);
        color_d    = fb.cmd_color;
        bank_d     = ~front_q;
      end
    end else if (wr_en_q) begin
      if (col_left_q != '0) begin
        addr_d     = addr_q + PW'(1);
        col_left_d = col_left_q - (XW+1)'(1);
      end else if (row_left_q != '0) begin
        row_base_d = row_base_q + PW'(SCREEN_WIDTH);
        addr_d     = row_base_q + PW'(SCREEN_WIDTH);
        col_left_d = width_q - (XW+1)'(1);
        row_left_d = row_left_q - (YW+1)'(1);
      end else begin
        wr_en_d = 1'b0;
      end
    end
  end

  // A swap is only taken while idle, so a frame is never shown half drawn.
  always_comb begin
    front_d = front_q;
    pend_d  = pend_q;
    if (frame_start_i && pend_q && (state_q == IDLE)) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
    end else if (swap_req_i && !pend_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      addr_q     <= '0;
      row_base_q <= '0;
      col_left_q <= '0;
      row_left_q <= '0;
      width_q    <= '0;
      color_q    <= '0;
      bank_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      err_q      <= 1'b0;
      front_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      col_left_q <= col_left_d;
      row_left_q <= row_left_d;
      width_q    <= width_d;
      color_q    <= color_d;
      bank_q     <= bank_d;
      wr_en_q    <= wr_en_d;
      err_q      <= err_d;
      front_q    <= front_d;
      pend_q     <= pend_d;
    end
  end

  assign fb.wr_en       = wr_en_q;
  assign fb.wr_addr     = {bank_q, addr_q};
  assign fb.wr_data     = color_q;
  assign front_bank_o   = front_q;
  assign swap_pending_o = pend_q;
  assign cmd_err_o      = err_q;
endmodule

// File: tb/tb_vga_fb_fill_engine.sv
// tb/tb_vga_fb_fill_engine.sv - self-checking bench for vga_fb_fill_engine (honours FB_CLIP_EN)
module tb_vga_fb_fill_engine;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int CD = 8;
  localparam int PW = 19;

  logic clk = 1'b0;
  logic rst;
  logic swap_req, frame_start;
  logic front, pend, busy, err;
  always #5 clk = ~clk;

  vga_fb_fill_engine_if #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .COLOR_DEPTH(CD)) ifc ();

  vga_fb_fill_engine #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .COLOR_DEPTH(CD)) dut (
    .sys_clk_i      (clk),
    .reset_i        (rst),
    .fb             (ifc),
    .swap_req_i     (swap_req),
    .frame_start_i  (frame_start),
    .front_bank_o   (front),
    .swap_pending_o (pend),
    .busy_o         (busy),
    .cmd_err_o      (err)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  int          nwr   = 0;
  logic [PW:0] qa[$];
  logic [23:0] qd[$];
  logic        mfront;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (ifc.wr_en === 1'b1) begin
      nwr++;
      chk("busy_during_write", busy, 1);
      chk("write_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        chk("wr_addr", ifc.wr_addr, qa[0]);
        chk("wr_data", ifc.wr_data, qd[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
    end else if (qa.size() != 0) begin
      chk("wr_contiguous", ifc.wr_en, 1);
    end
  endtask

  // Reference: rectangle clipped or rejected, then every pixel listed in raster order.
  task automatic model(input int x, input int y, input int w, input int h,
                       input logic [23:0] c, output bit rej);
    int ew, eh;
    rej = 0;
`ifdef FB_CLIP_EN
    if (x >= W || y >= H) begin
      ew = 0; eh = 0;
    end else begin
      ew = (x + w > W) ? W - x : w;
      eh = (y + h > H) ? H - y : h;
    end
`else
    if (x >= W || y >= H || x + w > W || y + h > H) begin
      rej = 1; ew = 0; eh = 0;
    end else begin
      ew = w; eh = h;
    end
`endif
    for (int r = 0; r < eh; r++)
      for (int k = 0; k < ew; k++) begin
        qa.push_back({~mfront, PW'((y + r) * W + x + k)});
        qd.push_back(c);
      end
  endtask

  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [23:0] c, output int acc);
    bit rej, done;
    done = 0;
    rej  = 0;
    acc  = -1;
    ifc.cmd_x     = x[9:0];
    ifc.cmd_y     = y[8:0];
    ifc.cmd_w     = w[10:0];
    ifc.cmd_h     = h[9:0];
    ifc.cmd_color = c;
    ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (ifc.cmd_ready === 1'b1) begin
        chk("idle_at_accept", busy, 0);
        acc = cyc_n;
        model(x, y, w, h, c, rej);
        cyc();
        done = 1;
        chk("cmd_err", err, rej);
        if (rej) begin
          chk("reject_ready", ifc.cmd_ready, 1);
          chk("reject_not_busy", busy, 0);
        end
      end else begin
        cyc();
      end
    end
    ifc.cmd_valid = 1'b0;
    chk("accept_timeout", done, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && (qa.size() != 0 || busy === 1'b1); i++) cyc();
    chk("drain", (qa.size() == 0) && (busy === 1'b0), 1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  initial begin
    int a1, a2;
    int rx, ry, rw, rh;
    rst = 1'b1; swap_req = 1'b0; frame_start = 1'b0; mfront = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_x = '0; ifc.cmd_y = '0;
    ifc.cmd_w = '0; ifc.cmd_h = '0; ifc.cmd_color = '0;
    cyc(); cyc();
    chk("rst_cmd_ready", ifc.cmd_ready, 0);
    chk("rst_wr_en", ifc.wr_en, 0);
    chk("rst_wr_addr", ifc.wr_addr, 0);
    chk("rst_wr_data", ifc.wr_data, 0);
    chk("rst_front", front, 0);
    chk("rst_pending", pend, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", ifc.cmd_ready, 1);

    nwr = 0;
    send(8, 2, 3, 2, 24'hFF0000, a1);
    chk("first_addr", ifc.wr_addr, {1'b1, 19'd1288});
    drain();
    chk("basic_count", nwr, 6);

    nwr = 0;
    send(0, 0, 3, 2, 24'h00AA55, a1);
    send(20, 5, 2, 2, 24'h123456, a2);
    chk("b2b_accept_gap", a2 - a1, 7);
    drain();
    chk("b2b_count", nwr, 10);

    send(100, 100, 10, 10, 24'h0000FF, a1);
    repeat (5) cyc();
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    chk("swap_pending_set", pend, 1);
    repeat (10) cyc();
    pulse_frame();
    chk("front_held_in_fill", front, 0);
    chk("pending_held_in_fill", pend, 1);
    drain();
    pulse_frame();
    chk("front_swapped", front, 1);
    chk("pending_cleared", pend, 0);
    mfront = 1'b1;

    swap_req = 1'b1; frame_start = 1'b1; cyc();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("same_cycle_pending", pend, 1);
    chk("same_cycle_front", front, 1);
    pulse_frame();
    chk("same_cycle_swapped", front, 0);
    mfront = 1'b0;

    swap_req = 1'b1;
    send(30, 40, 4, 1, 24'h777777, a1);
    swap_req = 1'b0;
    chk("swap_with_cmd_pending", pend, 1);
    drain();
    pulse_frame();
    chk("swap_with_cmd_front", front, 1);
    mfront = 1'b1;

    nwr = 0;
    send(638, 10, 4, 1, 24'h00FF00, a1);
    drain();
    cyc();
    chk("err_one_cycle", err, 0);
`ifdef FB_CLIP_EN
    chk("clip_x_count", nwr, 2);
`else
    chk("reject_x_count", nwr, 0);
`endif
    nwr = 0;
    send(0, 478, 2, 5, 24'h0F0F0F, a1);
    drain();
`ifdef FB_CLIP_EN
    chk("clip_y_count", nwr, 4);
`else
    chk("reject_y_count", nwr, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 620));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(450, 500)) : int'($urandom_range(0, 470));
      rw = int'($urandom_range(0, 24));
      rh = int'($urandom_range(0, 6));
      send(rx, ry, rw, rh, 24'($urandom), a1);
    end
    drain();

    nwr = 0;
    send(5, 5, 0, 3, 24'hABCDEF, a1);
    chk("zero_size_busy", busy, 1);
    cyc();
    chk("zero_size_idle", busy, 0);
    chk("zero_size_writes", nwr, 0);

    send(0, 0, 100, 10, 24'h555555, a1);
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    repeat (20) cyc();
    rst = 1'b1;
    qa.delete();
    qd.delete();
    cyc();
    chk("abort_wr_en", ifc.wr_en, 0);
    chk("abort_front", front, 0);
    chk("abort_pending", pend, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready_in_reset", ifc.cmd_ready, 0);
    mfront = 1'b0;
    rst = 1'b0;
    cyc();
    chk("abort_ready_after", ifc.cmd_ready, 1);
    nwr = 0;
    send(1, 1, 2, 2, 24'hC0FFEE, a1);
    drain();
    chk("after_reset_count", nwr, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
